// File: rtl/lz77_pkg.sv
// Shared types and helpers for the LZ77 stream decompressor.
//   state_e   : controller states (IDLE, COPY, LIT)
//   tok_dist  : distance field of a token, {dist, len, lit} layout
//   tok_len   : length field of a token
//   tok_lit   : literal byte of a token
// Tokens are passed zero-extended to TOK_MAX_W bits; the caller casts the
// result down to its own field width.
package lz77_pkg;

  localparam int TOK_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    LIT  = 2'd2
  } state_e;

  function automatic logic [TOK_MAX_W-1:0] field_mask(input int width);
    return (TOK_MAX_W'(1) << width) - TOK_MAX_W'(1);
  endfunction

  function automatic logic [TOK_MAX_W-1:0] tok_dist(input logic [TOK_MAX_W-1:0] tok,
                                                    input int dist_w,
                                                    input int len_w);
    return (tok >> (8 + len_w)) & field_mask(dist_w);
  endfunction

  function automatic logic [TOK_MAX_W-1:0] tok_len(input logic [TOK_MAX_W-1:0] tok,
                                                   input int len_w);
    return (tok >> 8) & field_mask(len_w);
  endfunction

  function automatic logic [7:0] tok_lit(input logic [TOK_MAX_W-1:0] tok);
    return tok[7:0];
  endfunction

endpackage

// File: rtl/lz77_history_ram.sv
// Sliding history window: 2^ADDR_W bytes, asynchronous read, synchronous
// write, every entry cleared to 0x00 by reset so stale references read 0.
//   clk, rst_n : clock, async active-low reset
//   i_we       : write enable
//   i_waddr    : write address
//   i_wdata    : write byte
//   i_raddr    : read address
//   o_rdata    : read byte (combinational)
module lz77_history_ram #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lz77_decomp_stream.sv
// Streaming LZ77 decompressor, AXI-Stream tokens in, AXI-Stream bytes out.
// Each token {dist, len, lit} copies len bytes from dist back in the history
// window, then emits lit; the literal of a TLAST token carries m_axis_tlast.
//   clk, rst_n                     : clock, async active-low reset
//   s_axis_tdata/tvalid/tready/tlast : token input
//   m_axis_tdata/tvalid/tready/tlast : byte output
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | s_axis_tready high, waiting for a token
// COPY  | emitting history bytes, r_cnt bytes left
// LIT   | emitting the literal byte, then back to IDLE
module lz77_decomp_stream
  import lz77_pkg::*;
#(
  parameter int DIST_WIDTH        = 4,
  parameter int LEN_WIDTH         = 4,
  parameter int WINDOW_ADDR_WIDTH = 4,
  parameter int TOKEN_W           = DIST_WIDTH + LEN_WIDTH + 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TOKEN_W-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast
);

  state_e                       r_state;
  logic                         r_s_tready;
  logic [DIST_WIDTH-1:0]        r_dist;
  logic [LEN_WIDTH-1:0]         r_cnt;
  logic [7:0]                   r_lit;
  logic                         r_last;
  logic [WINDOW_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [7:0]                   r_tdata;
  logic                         r_tvalid;
  logic                         r_tlast;

  logic [TOK_MAX_W-1:0]         w_tok;
  logic [DIST_WIDTH-1:0]        w_dist;
  logic [LEN_WIDTH-1:0]         w_len;
  logic                         w_gen;
  logic                         w_we;
  logic [7:0]                   w_wdata;
  logic [WINDOW_ADDR_WIDTH-1:0] w_rd_addr;
  logic [7:0]                   w_hist_rd;

  assign w_tok  = TOK_MAX_W'(s_axis_tdata);
  assign w_dist = DIST_WIDTH'(tok_dist(w_tok, DIST_WIDTH, LEN_WIDTH));
  assign w_len  = LEN_WIDTH'(tok_len(w_tok, LEN_WIDTH));

  // Output register can take a new byte when empty or being drained.
  assign w_gen     = !r_tvalid || m_axis_tready;
  assign w_rd_addr = r_wr_ptr - WINDOW_ADDR_WIDTH'(r_dist);
  // Every emitted byte, literal included, enters the history window.
  assign w_we      = w_gen && (r_state == COPY || r_state == LIT);
  assign w_wdata   = (r_state == COPY) ? w_hist_rd : r_lit;

  lz77_history_ram #(
    .ADDR_W (WINDOW_ADDR_WIDTH)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_hist_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_s_tready <= 1'b0;
      r_dist     <= '0;
      r_cnt      <= '0;
      r_lit      <= 8'h00;
      r_last     <= 1'b0;
      r_wr_ptr   <= '0;
      r_tdata    <= 8'h00;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
    end else begin
      // A consumed byte is dropped unless a new one replaces it below.
      if (m_axis_tready) r_tvalid <= 1'b0;

      unique case (r_state)
        IDLE: begin
          r_s_tready <= 1'b1;
          if (s_axis_tvalid && r_s_tready) begin
            r_dist     <= w_dist;
            r_lit      <= tok_lit(w_tok);
            r_last     <= s_axis_tlast;
            r_s_tready <= 1'b0;
            // dist=0 has no history to copy, so its length is ignored.
            if (w_len != '0 && w_dist != '0) begin
              r_cnt   <= w_len;
              r_state <= COPY;
            end else begin
              r_state <= LIT;
            end
          end
        end
        COPY: begin
          if (w_gen) begin
            r_tdata  <= w_hist_rd;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_wr_ptr <= r_wr_ptr + WINDOW_ADDR_WIDTH'(1);
            r_cnt    <= r_cnt - LEN_WIDTH'(1);
            if (r_cnt == LEN_WIDTH'(1)) r_state <= LIT;
          end
        end
        LIT: begin
          if (w_gen) begin
            r_tdata    <= r_lit;
            r_tvalid   <= 1'b1;
            r_tlast    <= r_last;
            r_wr_ptr   <= r_wr_ptr + WINDOW_ADDR_WIDTH'(1);
            r_state    <= IDLE;
            r_s_tready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

endmodule

// File: tb/tb_lz77_decomp_stream.sv
module tb_lz77_decomp_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  int n_tests = 0;
  int n_fail  = 0;
  int lo_cnt;

  logic [15:0] tok_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  out_q[$];
  logic        outl_q[$];

  always #5 clk = ~clk;

  lz77_decomp_stream dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Feeds tok_q (last token flagged TLAST), collects output bytes and checks
  // them against exp_q. Stalled outputs must hold data and TLAST.
  task automatic run(input string name, input bit rnd, input int budget);
    int    cyc = 0;
    bit    prev_stall = 0;
    logic [7:0] pd = 8'h00;
    logic  pl = 1'b0;
    bit    after_last = 0;
    bit    lo_done = 0;
    lo_cnt = 0;
    out_q.delete();
    outl_q.delete();
    while ((tok_q.size() != 0 || out_q.size() < exp_q.size()) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tok_q.size() != 0) begin
        s_tvalid = 1'b1;
        s_tdata  = tok_q[0];
        s_tlast  = (tok_q.size() == 1);
      end else begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
      #1;
      if (after_last && !lo_done) begin
        if (!s_tready) lo_cnt++;
        else lo_done = 1;
      end
      if (s_tvalid && s_tready) begin
        void'(tok_q.pop_front());
        if (tok_q.size() == 0) after_last = 1;
      end
      if (prev_stall) begin
        chk($sformatf("%s stall data", name), 32'(m_tdata), 32'(pd));
        chk($sformatf("%s stall last", name), 32'(m_tlast), 32'(pl));
        chk($sformatf("%s stall valid", name), 32'(m_tvalid), 32'd1);
      end
      if (m_tvalid && m_tready) begin
        out_q.push_back(m_tdata);
        outl_q.push_back(m_tlast);
      end
      prev_stall = m_tvalid && !m_tready;
      pd = m_tdata;
      pl = m_tlast;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    chk($sformatf("%s tokens consumed", name), 32'(tok_q.size()), 32'd0);
    chk($sformatf("%s byte count", name), 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      chk($sformatf("%s byte%0d", name, i), 32'(out_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s last%0d", name, i), 32'(outl_q[i]),
          32'(i == exp_q.size() - 1));
    end
    tok_q.delete();
    exp_q.delete();
  endtask

  task automatic accept_tok(input logic [15:0] tok, input logic last);
    int cyc = 0;
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = tok;
    s_tlast  = last;
    #1;
    while (!s_tready && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("midrst accept", 32'(s_tready), 32'd1);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic load_abcabcd();
    tok_q = '{16'h0041, 16'h0042, 16'h0043, 16'h3344};
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43, 8'h44};
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tdata  = 16'h0000;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    #1;
    chk("rst s_tready", 32'(s_tready), 32'd0);
    chk("rst m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst m_tdata", 32'(m_tdata), 32'd0);
    chk("rst m_tlast", 32'(m_tlast), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("tready before edge", 32'(s_tready), 32'd0);
    @(negedge clk);
    #1;
    chk("tready after edge", 32'(s_tready), 32'd1);

    tok_q = '{16'h0041, 16'h0042};
    exp_q = '{8'h41, 8'h42};
    run("literals", 1'b0, 100);

    tok_q = '{16'h0041, 16'h1341};
    exp_q = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41};
    run("overlap", 1'b0, 100);

    load_abcabcd();
    run("backref", 1'b0, 100);
    chk("backref tready low cycles", 32'(lo_cnt), 32'd4);

    for (int i = 0; i < 20; i++) tok_q.push_back(16'(i));
    tok_q.push_back(16'hFFFF);
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
    for (int i = 5; i <= 19; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hFF);
    run("wrap", 1'b0, 300);

    load_abcabcd();
    run("bp", 1'b1, 400);
    load_abcabcd();
    run("bp2", 1'b1, 400);

    accept_tok(16'h0041, 1'b0);
    accept_tok(16'h1F41, 1'b1);
    @(negedge clk);
    #1;
    chk("midrst copy busy", 32'(m_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst s_tready", 32'(s_tready), 32'd0);
    chk("midrst m_tdata", 32'(m_tdata), 32'd0);
    chk("midrst m_tlast", 32'(m_tlast), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tok_q = '{16'h2142};
    exp_q = '{8'h00, 8'h42};
    run("after reset", 1'b0, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lz77_decomp_stream.md
# lz77_decomp_stream

Streaming LZ77 decompressor between an upstream token source and a downstream byte sink, both AXI-Stream. Each input token is a (distance, length, literal) triple: the block copies `length` bytes from its sliding history window, starting `distance` bytes back, then emits the literal byte. Output is one byte per beat, with TLAST marking the final byte of the packet.

## Interface
- DIST_WIDTH, 4: width of the distance field.
- LEN_WIDTH, 4: width of the length field.
- WINDOW_ADDR_WIDTH, 4: history window depth is 2^WINDOW_ADDR_WIDTH bytes. Must satisfy WINDOW_ADDR_WIDTH >= DIST_WIDTH.
- TOKEN_W, DIST_WIDTH+LEN_WIDTH+8: token width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low; clock clk.
- s_axis_tdata  in  TOKEN_W  token = {dist[DIST_WIDTH-1:0], len[LEN_WIDTH-1:0], lit[7:0]}, with dist in the MSBs and lit in bits [7:0].
- s_axis_tvalid  in  1  token valid.
- s_axis_tready  out  1  block accepts a token.
- s_axis_tlast  in  1  this token is the last one of the packet.
- m_axis_tdata  out  8  decompressed byte.
- m_axis_tvalid  out  1  output byte valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last byte of the packet.

## Operation
- States:
  - IDLE: s_axis_tready=1.
  - COPY: emit history bytes.
  - LIT: emit the literal byte.
- In IDLE, a handshake (tvalid&&tready) latches dist, len, lit and the last flag.
  - Goes to COPY if len!=0 and dist!=0.
  - Otherwise goes to LIT. A token with dist=0 and len!=0 is treated as len=0.
- Output register: a new byte is generated whenever !m_axis_tvalid || m_axis_tready.
  - COPY byte = hist[wr_ptr - dist], subtraction mod 2^WINDOW_ADDR_WIDTH.
  - Each generated byte (copy or literal) is written to hist[wr_ptr] at the same edge, then wr_ptr increments mod window size.
  - Consequence: overlapping copies (len > dist) replicate correctly, e.g. dist=1 repeats the last byte.
- COPY decrements the remaining count per generated byte. After the last copy byte it goes to LIT.
- LIT generates the literal with m_axis_tlast = latched last flag, then goes to IDLE.
- m_axis_tlast is 0 on every other byte.
- Bytes per token = len+1, or 1 when dist=0.
- History, wr_ptr and state persist across packets. They are cleared only by reset.
- A reference to history never written since reset returns 0x00, because the window resets to 0x00.

## Timing
- Reset values:
  - s_axis_tready=0.
  - m_axis_tvalid=0, m_axis_tdata=0x00, m_axis_tlast=0.
  - state IDLE, wr_ptr=0, all history bytes 0x00.
- s_axis_tready is registered. It rises at the first clk edge after rst_n deasserts, and is 1 only in IDLE.
- Token accepted at edge k: first output byte is valid after edge k+1.
- With m_axis_tready=1, one byte per cycle follows.
- After the edge that generates the literal, s_axis_tready=1 again. Output and input operate concurrently, so the literal may still be pending.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable and no byte is generated or written.
- m_axis_tvalid drops after a handshake if no new byte is generated that edge.
- Reset asserted mid-token: all outputs go to reset values immediately. The partial token is discarded and the window is cleared.

## Structure
- Package lz77_pkg holds:
  - state enum (IDLE, COPY, LIT);
  - token field-slice helper functions (dist, len, lit), parameterized by widths.
- Sub-module lz77_history_ram:
  - 2^WINDOW_ADDR_WIDTH x 8 registers;
  - asynchronous read, synchronous write;
  - async-reset to 0x00.
- Top level contains the FSM, the output register and wr_ptr.

## Test plan
All cases use default parameters and m_axis_tready=1 unless noted.
- Literals only: tokens 0x0041, 0x0042 (last) -> bytes 0x41, 0x42; TLAST only on 0x42.
- Overlap copy: 0x0041, 0x1341 (dist1, len3, lit 'A', last) -> "AAAAA"; TLAST on byte 4 only.
- Back-reference: 0x0041, 0x0042, 0x0043, 0x3344 (last) -> "ABCABCD"; s_axis_tready low for 4 cycles during the last token.
- Wrap-around:
  - Stimulus: 20 literals 0x00..0x13, then dist15 len15 lit 0xFF.
  - Required response: the copy reproduces bytes 0x05..0x13, then 0xFF; TLAST on 0xFF.
- Backpressure: repeat the "ABCABCD" case with m_axis_tready toggling pseudo-randomly -> identical byte sequence; data and TLAST stable while stalled; no lost or duplicated bytes.
- Reset mid-copy: assert rst_n low during COPY -> m_axis_tvalid=0 and s_axis_tready=0 at once. Then a fresh 0x2142 token (dist2, len1, lit 'B') -> 0x00, 0x42, because the history was cleared to 0x00.
